// File: rtl/shift_pkg.sv
// Shared defaults, shift-amount width and FSM state encoding for the sequential
// shift arbiter.
package shift_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int STEP_DEF  = 4;
  localparam int AMT_W     = 5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: left, logical right or arithmetic right by
// 0..STEP bit positions.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF,
  parameter int SH_W  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SH_W-1:0]  amt,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] dout
);

  logic signed [WIDTH-1:0] sdin;
  logic signed [WIDTH-1:0] sra;

  // The arithmetic shift is kept in its own signed variable so the unsigned
  // arms of the select below cannot turn it into a logical shift.
  always_comb begin
    sdin = din;
    sra  = sdin >>> amt;
    if (left)
      dout = din << amt;
    else if (arith)
      dout = sra;
    else
      dout = din >> amt;
  end

endmodule

// File: rtl/shift_arbiter_seq.sv
// Two-requester round-robin front end feeding one shared multi-cycle shifter
// that moves at most STEP bits per cycle.
module shift_arbiter_seq
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int STEP  = STEP_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_data0,
  input  logic [WIDTH-1:0] req_data1,
  input  logic [AMT_W-1:0] req_amt0,
  input  logic [AMT_W-1:0] req_amt1,
  input  logic             req_arith0,
  input  logic             req_arith1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  localparam int SH_W = $clog2(STEP + 1);

  logic [1:0]              state;
  logic                    last_grant;
  logic [AMT_W-1:0]        remaining;
  logic [AMT_W-1:0]        rem_next;
  logic [WIDTH-1:0]        work;
  logic                    dir_left;
  logic                    arith_q;
  logic                    id_q;

  logic                    grant_id;
  logic [1:0]              grant_vec;
  logic                    accept;
  logic [WIDTH-1:0]        sel_data;
  logic signed [AMT_W-1:0] sel_amt;
  logic                    sel_arith;
  logic [AMT_W-1:0]        sel_mag;
  logic [SH_W-1:0]         sh_amt;
  logic [WIDTH-1:0]        step_out;

  // Round-robin grant: on a tie the requester not served last wins.
  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant;
      default: grant_id = 1'b0;
    endcase
    grant_vec = 2'b00;
    if (!reset && state == ST_IDLE && |req_valid)
      grant_vec = grant_id ? 2'b10 : 2'b01;
    accept = |(req_valid & grant_vec);
  end

  assign req_ready = grant_vec;

  always_comb begin
    sel_data  = grant_id ? req_data1  : req_data0;
    sel_amt   = grant_id ? req_amt1   : req_amt0;
    sel_arith = grant_id ? req_arith1 : req_arith0;
    // Negating -16 wraps back to 5'b10000, which reads as 16 unsigned.
    sel_mag   = sel_amt[AMT_W-1] ? $unsigned(-sel_amt) : $unsigned(sel_amt);
  end

  always_comb begin
    if (int'(remaining) > STEP)
      sh_amt = SH_W'(STEP);
    else
      sh_amt = SH_W'(remaining);
    rem_next = remaining - AMT_W'(sh_amt);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .SH_W  (SH_W)
  ) u_step (
    .din   (work),
    .amt   (sh_amt),
    .left  (dir_left),
    .arith (arith_q),
    .dout  (step_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      remaining  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            last_grant <= grant_id;
            remaining  <= sel_mag;
            state      <= (sel_mag == '0) ? ST_DONE : ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          remaining <= rem_next;
          if (rem_next == '0)
            state <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand path carries no reset; outputs are masked outside DONE instead.
  always_ff @(posedge clk) begin
    if (accept) begin
      work     <= sel_data;
      dir_left <= ~sel_amt[AMT_W-1];
      arith_q  <= sel_arith;
      id_q     <= grant_id;
    end else if (state == ST_SHIFT) begin
      work <= step_out;
    end
  end

  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_valid ? work : '0;
  assign rsp_id    = rsp_valid & id_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Bench for shift_arbiter_seq: directed vector table, arbitration and reset
// sequences, and randomized operations against an arithmetic reference model.
module tb_shift_arbiter_seq;

  localparam int WIDTH = 16;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data0, req_data1;
  logic [4:0]  req_amt0, req_amt1;
  logic        req_arith0, req_arith1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic              id;
    logic [15:0]       data;
    logic signed [4:0] amt;
    logic              arith;
    logic [15:0]       exp;
    int                lat;
  } vec_t;

  vec_t vecs[9];

  shift_arbiter_seq #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data0  (req_data0),
    .req_data1  (req_data1),
    .req_amt0   (req_amt0),
    .req_amt1   (req_amt1),
    .req_arith0 (req_arith0),
    .req_arith1 (req_arith1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: shift a zero-extended copy with plain operators, then OR in the
  // sign fill for arithmetic right shifts.
  function automatic logic [15:0] ref_shift(logic [15:0] d, logic signed [4:0] a, logic ar);
    int          n;
    logic [31:0] w;
    logic [31:0] fill;
    if (a >= 0) begin
      n = a;
      w = {16'd0, d} << n;
    end else begin
      n    = -int'(a);
      w    = {16'd0, d} >> n;
      fill = (ar && d[15]) ? (32'h0000_FFFF & ~(32'h0000_FFFF >> n)) : 32'd0;
      w    = w | fill;
    end
    return w[15:0];
  endfunction

  function automatic int ref_lat(logic signed [4:0] a);
    int n;
    n = (a < 0) ? -int'(a) : int'(a);
    return (n + STEP - 1) / STEP;
  endfunction

  task automatic scramble();
    req_data0  = 16'($urandom);
    req_data1  = 16'($urandom);
    req_amt0   = 5'($urandom);
    req_amt1   = 5'($urandom);
    req_arith0 = 1'($urandom);
    req_arith1 = 1'($urandom);
  endtask

  // Called at a negedge; returns at a negedge after the response handshake.
  task automatic run_op(input logic id, input logic [15:0] data, input logic [4:0] amt,
                        input logic arith, input int hold,
                        output logic [15:0] got, output logic gid, output int lat,
                        output bit ok);
    int waits;
    ok  = 1'b1;
    got = '0;
    gid = 1'b0;
    lat = 0;
    if (id) begin
      req_data1 = data; req_amt1 = amt; req_arith1 = arith; req_valid = 2'b10;
    end else begin
      req_data0 = data; req_amt0 = amt; req_arith0 = arith; req_valid = 2'b01;
    end
    waits = 0;
    #1;
    while (!req_ready[id] && waits < 20) begin
      @(posedge clk);
      @(negedge clk);
      waits++;
    end
    if (!req_ready[id]) begin
      ok        = 1'b0;
      req_valid = 2'b00;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    scramble();
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!rsp_valid) begin
      ok = 1'b0;
      return;
    end
    got = rsp_data;
    gid = rsp_id;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] got;
    logic        gid;
    int          lat;
    bit          ok;
    int          seen;
    logic [15:0] held;

    reset     = 1'b1;
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    scramble();

    vecs[0] = '{1'b0, 16'h0001, 5'sh0F, 1'b0, 16'h8000, 4};
    vecs[1] = '{1'b1, 16'h8000, 5'sh11, 1'b1, 16'hFFFF, 4};
    vecs[2] = '{1'b1, 16'h8000, 5'sh11, 1'b0, 16'h0001, 4};
    vecs[3] = '{1'b0, 16'h1234, 5'sh10, 1'b0, 16'h0000, 4};
    vecs[4] = '{1'b0, 16'h9234, 5'sh10, 1'b1, 16'hFFFF, 4};
    vecs[5] = '{1'b1, 16'h00F0, 5'sh00, 1'b0, 16'h00F0, 0};
    vecs[6] = '{1'b0, 16'h00F0, 5'sh04, 1'b0, 16'h0F00, 1};
    vecs[7] = '{1'b1, 16'hF000, 5'sh1B, 1'b1, 16'hFF80, 2};
    vecs[8] = '{1'b0, 16'hABCD, 5'sh01, 1'b0, 16'h579A, 1};

    // Reset state with both requesters asserting
    @(negedge clk);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data",  rsp_data,  16'h0);
    check("rst_rsp_id",    rsp_id,    1'b0);
    check("rst_busy",      busy,      1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    reset     = 1'b0;
    req_valid = 2'b00;
    @(negedge clk);

    // Tie after reset: requester 0 first, then 1, then a fresh tie goes to 0
    req_data0 = 16'h1111; req_amt0 = 5'd0; req_arith0 = 1'b0;
    req_data1 = 16'h2222; req_amt1 = 5'd0; req_arith1 = 1'b0;
    req_valid = 2'b11;
    #1 check("tie1_ready", req_ready, 2'b01);
    @(posedge clk);
    @(negedge clk);
    check("tie1_valid", rsp_valid, 1'b1);
    check("tie1_id",    rsp_id,    1'b0);
    check("tie1_data",  rsp_data,  16'h1111);
    check("tie1_ready_done", req_ready, 2'b00);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check("tie2_ready", req_ready, 2'b10);
    check("tie2_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("tie2_valid", rsp_valid, 1'b1);
    check("tie2_id",    rsp_id,    1'b1);
    check("tie2_data",  rsp_data,  16'h2222);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check("tie3_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) begin
      run_op(vecs[i].id, vecs[i].data, vecs[i].amt, vecs[i].arith, 0, got, gid, lat, ok);
      check($sformatf("vec%0d_done", i), ok, 1'b1);
      check($sformatf("vec%0d_data", i), got, vecs[i].exp);
      check($sformatf("vec%0d_id", i), gid, vecs[i].id);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
    end

    // Response held with rsp_ready low while both requesters assert
    req_data1 = 16'h0F0F; req_amt1 = 5'd3; req_arith1 = 1'b0; req_valid = 2'b10;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    seen = 0;
    while (!rsp_valid && seen < 20) begin
      @(posedge clk);
      @(negedge clk);
      seen++;
    end
    held = ref_shift(16'h0F0F, 5'sd3, 1'b0);
    req_valid = 2'b11;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_data",  rsp_data,  held);
      check("hold_id",    rsp_id,    1'b1);
      check("hold_ready", req_ready, 2'b00);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during a +12 shift aborts the operation
    req_data0 = 16'h00FF; req_amt0 = 5'd12; req_arith0 = 1'b0; req_valid = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    check("abort_busy_before", busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy",      busy,      1'b0);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_rsp_data",  rsp_data,  16'h0);
    check("abort_rsp_id",    rsp_id,    1'b0);
    check("abort_req_ready", req_ready, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    check("abort_no_response", seen, 0);
    req_amt0 = 5'd0; req_amt1 = 5'd0; req_valid = 2'b11;
    #1 check("abort_ptr_reset", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);

    // Randomized operations against the reference model
    for (int r = 0; r < 40; r++) begin
      logic        rid;
      logic [15:0] rdata;
      logic [4:0]  ramt;
      logic        rar;
      rid   = 1'($urandom);
      rdata = 16'($urandom);
      ramt  = 5'($urandom);
      rar   = 1'($urandom);
      run_op(rid, rdata, ramt, rar, int'($urandom_range(0, 3)), got, gid, lat, ok);
      check($sformatf("rnd%0d_done", r), ok, 1'b1);
      check($sformatf("rnd%0d_data", r), got, ref_shift(rdata, $signed(ramt), rar));
      check($sformatf("rnd%0d_id", r), gid, rid);
      check($sformatf("rnd%0d_lat", r), lat, ref_lat($signed(ramt)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
